// File: rtl/ro_puf_response_gen.sv
// Ring-oscillator PUF response generator.
// A challenge picks two oscillators. Only that pair is enabled, and each one's
// rising edges are counted over a fixed window of clk cycles. The response bit
// is 1 when oscillator A produced more edges than oscillator B.
module ro_puf_response_gen #(
    parameter int NUM_RO = 16,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 4,
    parameter int WINDOW = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel_a,
    input  logic [SEL_W-1:0]  sel_b,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_enable,
    output logic              busy,
    output logic              resp_valid,
    output logic              response,
    output logic              tie,
    output logic              err,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b
);

    // The timer holds SETTLE-1 (at most 254) or WINDOW-1 (at most 2^20-1).
    localparam int TMR_W = 21;
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [SEL_W-1:0]  r_sel [2];     // [0] = oscillator A, [1] = oscillator B
    logic [CNT_W-1:0]  r_cnt [2];
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_sync3;

    logic [NUM_RO-1:0] r_ro_enable;
    logic              r_busy;
    logic              r_resp_valid;
    logic              r_response;
    logic              r_tie;
    logic              r_err;
    logic [CNT_W-1:0]  r_count_a;
    logic [CNT_W-1:0]  r_count_b;

    logic [1:0]        w_sel_ok;
    logic [1:0]        w_ro_sel;
    logic [NUM_RO-1:0] w_en_mask;
    logic              w_illegal;

    // Per-channel range check and oscillator mux (out-of-range index reads 0).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            assign w_sel_ok[gi] = (32'(r_sel[gi]) < 32'(NUM_RO));
            assign w_ro_sel[gi] = w_sel_ok[gi] ? ro_in[r_sel[gi]] : 1'b0;
        end
    endgenerate

    // One-hot enable for each selected oscillator; the pair mask has two bits set.
    generate
        for (gi = 0; gi < NUM_RO; gi++) begin : g_en
            assign w_en_mask[gi] = (r_sel[0] == SEL_W'(gi)) || (r_sel[1] == SEL_W'(gi));
        end
    endgenerate

    assign w_illegal = (r_sel[0] == r_sel[1]) || !w_sel_ok[0] || !w_sel_ok[1];

    // Challenge sequencing with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_sel[0]     <= '0;
            r_sel[1]     <= '0;
            r_ro_enable  <= '0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_response   <= 1'b0;
            r_tie        <= 1'b0;
            r_err        <= 1'b0;
            r_count_a    <= '0;
            r_count_b    <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel[0] <= sel_a;
                        r_sel[1] <= sel_b;
                        r_busy   <= 1'b1;
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_illegal) begin
                        r_err        <= 1'b1;
                        r_response   <= 1'b0;
                        r_tie        <= 1'b0;
                        r_count_a    <= '0;
                        r_count_b    <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_ro_enable <= w_en_mask;
                        r_timer     <= SETTLE_LD;
                        r_state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_timer == '0) begin
                        r_timer <= WINDOW_LD;
                        r_state <= S_MEASURE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (r_timer == '0) begin
                        r_ro_enable <= '0;
                        r_state     <= S_COMPARE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_COMPARE: begin
                    r_response   <= (r_cnt[0] > r_cnt[1]);
                    r_tie        <= (r_cnt[0] == r_cnt[1]);
                    r_count_a    <= r_cnt[0];
                    r_count_b    <= r_cnt[1];
                    r_err        <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Synchronize each selected oscillator and count its rising edges during MEASURE.
    // Sync flops are flushed in CHECK so a previous challenge's level cannot look
    // like a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst || (r_state == S_CHECK)) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync3  <= '0;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_sync1 <= w_ro_sel;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            for (int ch = 0; ch < 2; ch++) begin
                if ((r_state == S_MEASURE) && r_sync2[ch] && !r_sync3[ch]
                    && (r_cnt[ch] != {CNT_W{1'b1}})) begin
                    r_cnt[ch] <= r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    assign ro_enable  = r_ro_enable;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;
    assign response   = r_response;
    assign tie        = r_tie;
    assign err        = r_err;
    assign count_a    = r_count_a;
    assign count_b    = r_count_b;

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// Testbench for ro_puf_response_gen: drives synthetic square-wave oscillators
// and checks responses, counts, latency and enables against expectations
// derived from the wave periods.
module tb_ro_puf_response_gen;

    localparam int WIN = 64;
    localparam int SET = 4;
    localparam int LEGAL_LAT = 1 + SET + WIN + 2;   // 71

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ro_in = '0;

    // Main instance (CNT_W = 16)
    logic        start = 1'b0;
    logic [3:0]  sel_a = '0, sel_b = '0;
    logic [15:0] ro_enable, count_a, count_b;
    logic        busy, resp_valid, response, tie, err;

    // Narrow-counter instance (CNT_W = 4) for saturation
    logic        s_start = 1'b0;
    logic [3:0]  s_sel_a = '0, s_sel_b = '0;
    logic [15:0] s_ro_enable;
    logic [3:0]  s_count_a, s_count_b;
    logic        s_busy, s_resp_valid, s_response, s_tie, s_err;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;

    // Oscillator model: period in clk cycles (0 = held low), phase offset.
    int period [16];
    int phase  [16];

    ro_puf_response_gen #(.NUM_RO(16), .SEL_W(4), .CNT_W(16), .SETTLE(SET), .WINDOW(WIN)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b), .ro_in(ro_in),
        .ro_enable(ro_enable), .busy(busy), .resp_valid(resp_valid), .response(response),
        .tie(tie), .err(err), .count_a(count_a), .count_b(count_b)
    );

    ro_puf_response_gen #(.NUM_RO(16), .SEL_W(4), .CNT_W(4), .SETTLE(SET), .WINDOW(WIN)) u_dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .sel_a(s_sel_a), .sel_b(s_sel_b), .ro_in(ro_in),
        .ro_enable(s_ro_enable), .busy(s_busy), .resp_valid(s_resp_valid), .response(s_response),
        .tie(s_tie), .err(s_err), .count_a(s_count_a), .count_b(s_count_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator waves change mid-cycle, away from the sampling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (period[i] == 0) ro_in[i] = 1'b0;
            else ro_in[i] = (((cyc + phase[i]) % period[i]) < (period[i] / 2));
        end
    end

    // Instance under test for run_challenge: 0 = main, 1 = narrow counter.
    bit          cur = 1'b0;
    logic        m_rv, m_busy;
    logic [15:0] m_en;
    assign m_rv   = cur ? s_resp_valid : resp_valid;
    assign m_busy = cur ? s_busy : busy;
    assign m_en   = cur ? s_ro_enable : ro_enable;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one challenge and wait for resp_valid. Returns latency (cycles from
    // the start cycle to the resp_valid cycle), OR of all ro_enable values seen,
    // whether any enable value other than 0/exp_mask appeared, and busy in the
    // cycle after resp_valid. Optionally pulses start (with swapped selects)
    // twice during MEASURE.
    task automatic run_challenge(input bit inst, input logic [3:0] sa, input logic [3:0] sb,
                                 input logic [15:0] exp_mask, input bit inject,
                                 output int lat, output logic [15:0] en_or,
                                 output bit en_bad, output logic busy_after);
        cur    = inst;
        en_or  = '0;
        en_bad = 1'b0;
        if (inst) begin s_start = 1'b1; s_sel_a = sa; s_sel_b = sb; end
        else      begin start   = 1'b1; sel_a   = sa; sel_b   = sb; end
        step();
        s_start = 1'b0;
        start   = 1'b0;
        lat = 1;
        while (1) begin
            if ((m_en !== 16'h0000) && (m_en !== exp_mask)) en_bad = 1'b1;
            en_or = en_or | m_en;
            if (m_rv === 1'b1) break;
            if (lat >= 500) begin
                tests_run++;
                fails++;
                $display("FAIL timeout: resp_valid not seen within %0d cycles (a=%0d b=%0d)", lat, sa, sb);
                break;
            end
            if (inject && (lat == 30 || lat == 45)) begin
                if (inst) begin s_start = 1'b1; s_sel_a = sb; s_sel_b = sa; end
                else      begin start   = 1'b1; sel_a   = sb; sel_b   = sa; end
            end else begin
                s_start = 1'b0;
                start   = 1'b0;
            end
            step();
            lat++;
        end
        s_start = 1'b0;
        start   = 1'b0;
        step();
        busy_after = m_busy;
        if (inst)
            $display("[TB] challenge inst=sat a=%0d b=%0d lat=%0d resp=%0b tie=%0b err=%0b cnt_a=%0d cnt_b=%0d",
                     sa, sb, lat, s_response, s_tie, s_err, s_count_a, s_count_b);
        else
            $display("[TB] challenge inst=main a=%0d b=%0d lat=%0d resp=%0b tie=%0b err=%0b cnt_a=%0d cnt_b=%0d",
                     sa, sb, lat, response, tie, err, count_a, count_b);
    endtask

    function automatic bit near(input int obs, input int exp_v);
        return (obs >= exp_v - 1) && (obs <= exp_v + 1);
    endfunction

    task automatic set_wave(input int ch, input int p, input int ph);
        period[ch] = p;
        phase[ch]  = ph;
    endtask

    task automatic test_reset();
        int lat; logic [15:0] en_or; bit en_bad; logic ba;
        rst = 1'b0; start = 1'b1; sel_a = 4'd0; sel_b = 4'd1;
        step(); step(); step();
        tests_run++;
        if ({ro_enable, busy, resp_valid, response, tie, err, count_a, count_b} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: en=%h busy=%b rv=%b resp=%b tie=%b err=%b ca=%0d cb=%0d, required all 0",
                     ro_enable, busy, resp_valid, response, tie, err, count_a, count_b);
        end
        tests_run++;
        if ({s_ro_enable, s_busy, s_resp_valid, s_count_a, s_count_b} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_sat: en=%h busy=%b, required all 0", s_ro_enable, s_busy);
        end
        rst = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_busy: busy=%b required 1", busy);
        end
        // Let that challenge finish, checking its latency from the CHECK cycle.
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 500) begin step(); lat++; end
        tests_run++;
        if (lat != LEGAL_LAT) begin
            fails++;
            $display("FAIL reset_first_latency: got %0d required %0d", lat, LEGAL_LAT);
        end
        step();
        $display("[TB] challenge inst=main a=0 b=1 lat=%0d (post-reset)", lat);
        ba = busy; en_or = '0; en_bad = 0;
    endtask

    task automatic test_basic();
        int lat; logic [15:0] en_or; bit en_bad; logic ba;
        set_wave(3, 4, 0);
        set_wave(7, 8, 0);
        run_challenge(1'b0, 4'd3, 4'd7, 16'h0088, 1'b0, lat, en_or, en_bad, ba);
        tests_run++;
        if (lat != LEGAL_LAT) begin fails++; $display("FAIL basic_latency: got %0d required %0d", lat, LEGAL_LAT); end
        tests_run++;
        if (en_bad || en_or !== 16'h0088) begin fails++; $display("FAIL basic_enable: or=%h bad=%0b required 0088", en_or, en_bad); end
        tests_run++;
        if (response !== 1'b1 || tie !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL basic_result: resp=%b tie=%b err=%b required 1 0 0", response, tie, err);
        end
        tests_run++;
        if (!near(int'(count_a), WIN / 4) || !near(int'(count_b), WIN / 8)) begin
            fails++; $display("FAIL basic_counts: a=%0d b=%0d required %0d+-1 %0d+-1", count_a, count_b, WIN / 4, WIN / 8);
        end
        tests_run++;
        if (ro_enable !== 16'h0) begin fails++; $display("FAIL basic_enable_off: en=%h required 0", ro_enable); end
    endtask

    task automatic test_swap_and_tie();
        int lat; logic [15:0] en_or; bit en_bad; logic ba;
        run_challenge(1'b0, 4'd7, 4'd3, 16'h0088, 1'b0, lat, en_or, en_bad, ba);
        tests_run++;
        if (response !== 1'b0 || tie !== 1'b0 || !near(int'(count_a), WIN / 8) || !near(int'(count_b), WIN / 4)) begin
            fails++; $display("FAIL swap_result: resp=%b tie=%b a=%0d b=%0d required 0 0 %0d %0d",
                              response, tie, count_a, count_b, WIN / 8, WIN / 4);
        end
        set_wave(3, 6, 2);
        set_wave(7, 6, 2);
        run_challenge(1'b0, 4'd3, 4'd7, 16'h0088, 1'b0, lat, en_or, en_bad, ba);
        tests_run++;
        if (tie !== 1'b1 || response !== 1'b0 || count_a !== count_b || !near(int'(count_a), WIN / 6)) begin
            fails++; $display("FAIL tie_result: tie=%b resp=%b a=%0d b=%0d required 1 0 equal ~%0d",
                              tie, response, count_a, count_b, WIN / 6);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [15:0] en_or; bit en_bad; logic ba;
        run_challenge(1'b0, 4'd5, 4'd5, 16'h0000, 1'b0, lat, en_or, en_bad, ba);
        tests_run++;
        if (lat != 2) begin fails++; $display("FAIL illegal_latency: got %0d required 2", lat); end
        tests_run++;
        if (err !== 1'b1 || response !== 1'b0 || tie !== 1'b0 || count_a !== 16'd0 || count_b !== 16'd0) begin
            fails++; $display("FAIL illegal_result: err=%b resp=%b tie=%b a=%0d b=%0d required 1 0 0 0 0",
                              err, response, tie, count_a, count_b);
        end
        tests_run++;
        if (en_or !== 16'h0) begin fails++; $display("FAIL illegal_enable: or=%h required 0", en_or); end
        set_wave(3, 4, 1);
        set_wave(7, 8, 3);
        run_challenge(1'b0, 4'd3, 4'd7, 16'h0088, 1'b0, lat, en_or, en_bad, ba);
        tests_run++;
        if (err !== 1'b0 || response !== 1'b1) begin
            fails++; $display("FAIL illegal_clear: err=%b resp=%b required 0 1", err, response);
        end
    endtask

    task automatic test_saturation_ignore();
        int lat; logic [15:0] en_or; bit en_bad; logic ba;
        set_wave(2, 2, 0);
        set_wave(9, 0, 0);
        run_challenge(1'b1, 4'd2, 4'd9, 16'h0204, 1'b1, lat, en_or, en_bad, ba);
        tests_run++;
        if (lat != LEGAL_LAT) begin fails++; $display("FAIL sat_latency: got %0d required %0d", lat, LEGAL_LAT); end
        tests_run++;
        if (s_count_a !== 4'd15 || s_count_b !== 4'd0 || s_response !== 1'b1 || s_tie !== 1'b0) begin
            fails++; $display("FAIL sat_counts: a=%0d b=%0d resp=%b tie=%b required 15 0 1 0",
                              s_count_a, s_count_b, s_response, s_tie);
        end
        tests_run++;
        if (en_bad || en_or !== 16'h0204) begin fails++; $display("FAIL sat_enable: or=%h bad=%0b required 0204", en_or, en_bad); end
        tests_run++;
        if (ba !== 1'b0) begin fails++; $display("FAIL sat_injected_start_queued: busy=%b required 0", ba); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] en_or; bit en_bad; logic ba;
        set_wave(3, 4, 0);
        set_wave(7, 8, 0);
        run_challenge(1'b0, 4'd3, 4'd7, 16'h0088, 1'b0, lat, en_or, en_bad, ba);
        tests_run++;
        if (ba !== 1'b0) begin fails++; $display("FAIL b2b_busy_after: busy=%b required 0", ba); end
        run_challenge(1'b0, 4'd7, 4'd3, 16'h0088, 1'b0, lat, en_or, en_bad, ba);
        tests_run++;
        if (lat != LEGAL_LAT || response !== 1'b0) begin
            fails++; $display("FAIL b2b_second: lat=%0d resp=%b required %0d 0", lat, response, LEGAL_LAT);
        end
    endtask

    task automatic test_mid_reset();
        int lat; logic [15:0] en_or; bit en_bad; logic ba;
        set_wave(3, 4, 0);
        set_wave(7, 8, 0);
        start = 1'b1; sel_a = 4'd3; sel_b = 4'd7;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) step();
        rst = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0 || ro_enable !== 16'h0 || count_a !== 16'd0 || count_b !== 16'd0 || resp_valid !== 1'b0) begin
            fails++; $display("FAIL midreset_state: busy=%b en=%h a=%0d b=%0d rv=%b required all 0",
                              busy, ro_enable, count_a, count_b, resp_valid);
        end
        rst = 1'b1;
        step();
        run_challenge(1'b0, 4'd3, 4'd7, 16'h0088, 1'b0, lat, en_or, en_bad, ba);
        tests_run++;
        if (lat != LEGAL_LAT || !near(int'(count_a), WIN / 4) || !near(int'(count_b), WIN / 8) || response !== 1'b1) begin
            fails++; $display("FAIL midreset_recover: lat=%0d a=%0d b=%0d resp=%b required %0d %0d+-1 %0d+-1 1",
                              lat, count_a, count_b, response, LEGAL_LAT, WIN / 4, WIN / 8);
        end
    endtask

    task automatic test_random();
        int plist [4];
        int lat; logic [15:0] en_or; bit en_bad; logic ba;
        logic [3:0] sa, sb;
        int ia, ib, ea, eb;
        logic [15:0] mask;
        plist[0] = 4; plist[1] = 8; plist[2] = 16; plist[3] = 32;
        for (int it = 0; it < 8; it++) begin
            sa = 4'($urandom_range(0, 15));
            sb = 4'($urandom_range(0, 14));
            if (sb >= sa) sb = sb + 4'd1;
            ia = $urandom_range(0, 3);
            ib = $urandom_range(0, 2);
            if (ib >= ia) ib = ib + 1;
            set_wave(int'(sa), plist[ia], $urandom_range(0, plist[ia] - 1));
            set_wave(int'(sb), plist[ib], $urandom_range(0, plist[ib] - 1));
            ea = WIN / plist[ia];
            eb = WIN / plist[ib];
            mask = '0;
            mask[sa] = 1'b1;
            mask[sb] = 1'b1;
            run_challenge(1'b0, sa, sb, mask, 1'b0, lat, en_or, en_bad, ba);
            tests_run++;
            if (lat != LEGAL_LAT || en_bad || en_or !== mask || response !== (ea > eb) || tie !== 1'b0
                || !near(int'(count_a), ea) || !near(int'(count_b), eb)) begin
                fails++;
                $display("FAIL random_%0d: lat=%0d en=%h resp=%b tie=%b a=%0d b=%0d required %0d %h %b 0 %0d+-1 %0d+-1",
                         it, lat, en_or, response, tie, count_a, count_b, LEGAL_LAT, mask, (ea > eb), ea, eb);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            period[i] = 0;
            phase[i]  = 0;
        end
        test_reset();
        test_basic();
        test_swap_and_tie();
        test_illegal();
        test_saturation_ignore();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
